rv_fetch_branch_unit: RTL and testbench

//  Parametrised instruction-fetch and control-flow unit for the RV32I core.

---
 rtl/rv_fetch_branch_unit_if.sv | 60 ++++++
 rtl/rv_fetch_branch_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_rv_fetch_branch_unit.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_fetch_branch_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rv_fetch_branch_unit_if
//  Description : Bundle of the fetch/branch unit's external signals.
//                - imem request channel:   imem_req_valid/addr/ready
//                - imem response channel:  imem_rsp_valid/data
//                - decode handshake:       if_valid/pc/instr/ready
//                - execute resolution:     ex_valid/kind/funct3/pc/rs1/rs2/imm
//                - control outputs:        redirect, trap, trap_pc
//                modport master: the fetch/branch unit itself.
//                modport slave : the surrounding imem/decode/execute logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rv_fetch_branch_unit_if #(
    parameter int PC_WIDTH = 8,
    parameter int XLEN     = 32
);
    logic                imem_req_valid;
    logic [PC_WIDTH-1:0] imem_req_addr;
    logic                imem_req_ready;
    logic                imem_rsp_valid;
    logic [31:0]         imem_rsp_data;

    logic                if_valid;
    logic [PC_WIDTH-1:0] if_pc;
    logic [31:0]         if_instr;
    logic                if_ready;

    logic                ex_valid;
    logic [1:0]          ex_kind;
    logic [2:0]          ex_funct3;
    logic [PC_WIDTH-1:0] ex_pc;
    logic [XLEN-1:0]     ex_rs1;
    logic [XLEN-1:0]     ex_rs2;
    logic [XLEN-1:0]     ex_imm;

    logic                redirect;
    logic                trap;
    logic [PC_WIDTH-1:0] trap_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_valid, if_pc, if_instr,
        input  if_ready,
        input  ex_valid, ex_kind, ex_funct3, ex_pc, ex_rs1, ex_rs2, ex_imm,
        output redirect, trap, trap_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_pc, if_instr,
        output if_ready,
        output ex_valid, ex_kind, ex_funct3, ex_pc, ex_rs1, ex_rs2, ex_imm,
        input  redirect, trap, trap_pc
    );
endinterface
`default_nettype wire

// File: rtl/rv_fetch_branch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rv_fetch_branch_unit
//  Description : RV32I instruction fetch and control-flow resolution.
//                Keeps the PC, issues single-outstanding fetches to a
//                variable-latency imem, hands words to decode over
//                valid/ready, resolves branches/JAL/JALR and squashes
//                wrong-path fetches on redirect.
//  Ports       : clk    - rising-edge clock
//                reset  - synchronous, active-high
//                bus    - rv_fetch_branch_unit_if.master (imem, decode,
//                         execute and redirect/trap signals)
//  Config      : MISALIGN_TRAP_EN - when defined, a taken target with
//                nonzero low two bits pulses trap and halts fetch until
//                reset; when undefined the low target bits are forced to 00.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_fetch_branch_unit #(
    parameter int                  PC_WIDTH = 8,
    parameter int                  XLEN     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  wire logic               clk,
    input  wire logic               reset,
    rv_fetch_branch_unit_if.master  bus
);

    localparam logic [1:0] c_KIND_BRANCH = 2'b00;
    localparam logic [1:0] c_KIND_JAL    = 2'b01;
    localparam logic [1:0] c_KIND_JALR   = 2'b10;

    localparam logic [PC_WIDTH-1:0] c_PC_STEP    = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] c_BIT0_MASK  = PC_WIDTH'(1);
`ifndef MISALIGN_TRAP_EN
    localparam logic [PC_WIDTH-1:0] c_ALIGN_MASK = PC_WIDTH'(3);
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3
`ifdef MISALIGN_TRAP_EN
        ,
        S_HALT = 3'd4
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                drop_q, drop_d;
    logic [PC_WIDTH-1:0] if_pc_q, if_pc_d;
    logic [31:0]         if_instr_q, if_instr_d;

    // ------------------------------------------------------------------
    // Branch condition and target resolution (purely combinational)
    // ------------------------------------------------------------------
    logic                w_br_taken;
    logic                w_taken;
    logic                w_redirect;
    logic [PC_WIDTH-1:0] w_jalr_sum;
    logic [PC_WIDTH-1:0] w_raw_target;
    logic [PC_WIDTH-1:0] w_target;
    logic                w_misalign;

    always_comb begin
        w_br_taken = 1'b0;
        unique case (bus.ex_funct3)
            3'b000:  w_br_taken = (bus.ex_rs1 == bus.ex_rs2);
            3'b001:  w_br_taken = (bus.ex_rs1 != bus.ex_rs2);
            3'b100:  w_br_taken = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
            3'b101:  w_br_taken = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
            3'b110:  w_br_taken = (bus.ex_rs1 <  bus.ex_rs2);
            3'b111:  w_br_taken = (bus.ex_rs1 >= bus.ex_rs2);
            default: w_br_taken = 1'b0;   // 010/011 are not branch encodings
        endcase
    end

    assign w_taken    = ((bus.ex_kind == c_KIND_BRANCH) && w_br_taken)
                      || (bus.ex_kind == c_KIND_JAL)
                      || (bus.ex_kind == c_KIND_JALR);
    assign w_redirect = bus.ex_valid & w_taken;

    // Only the low PC_WIDTH bits of rs1+imm survive, so add at that width.
    assign w_jalr_sum   = bus.ex_rs1[PC_WIDTH-1:0] + bus.ex_imm[PC_WIDTH-1:0];
    assign w_raw_target = (bus.ex_kind == c_KIND_JALR)
                        ? (w_jalr_sum & ~c_BIT0_MASK)
                        : (bus.ex_pc + bus.ex_imm[PC_WIDTH-1:0]);

`ifdef MISALIGN_TRAP_EN
    logic                r_trap_q, r_trap_d;
    logic [PC_WIDTH-1:0] trap_pc_q, trap_pc_d;

    assign w_target   = w_raw_target;
    // A halted unit raises no further traps, keeping the pulse single.
    assign w_misalign = w_redirect && (w_raw_target[1:0] != 2'b00)
                      && (state_q != S_HALT);
    assign bus.trap    = r_trap_q;
    assign bus.trap_pc = trap_pc_q;
`else
    assign w_target    = w_raw_target & ~c_ALIGN_MASK;
    assign w_misalign  = 1'b0;
    assign bus.trap    = 1'b0;
    assign bus.trap_pc = '0;
`endif

    // ------------------------------------------------------------------
    // Fetch FSM: next state and outputs
    // ------------------------------------------------------------------
    logic w_req_valid;
    logic w_if_valid;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        if_pc_d     = if_pc_q;
        if_instr_d  = if_instr_q;
        w_req_valid = 1'b0;
        w_if_valid  = 1'b0;
`ifdef MISALIGN_TRAP_EN
        r_trap_d    = 1'b0;
        trap_pc_d   = trap_pc_q;
`endif

        if (w_redirect) begin
            pc_d = w_target;
        end

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                w_req_valid = 1'b1;
                if (bus.imem_req_ready) begin
                    state_d = S_WAIT;
                    // The accepted request is now wrong-path; eat its reply.
                    if (w_redirect) begin
                        drop_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (drop_q || w_redirect) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        state_d    = S_HOLD;
                        if_pc_d    = pc_q;
                        if_instr_d = bus.imem_rsp_data;
                    end
                end else if (w_redirect) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                // Suppressed during redirect so decode never takes the
                // wrong-path word.
                w_if_valid = ~w_redirect;
                if (w_redirect) begin
                    state_d = S_REQ;
                end else if (bus.if_ready) begin
                    state_d = S_REQ;
                    pc_d    = pc_q + c_PC_STEP;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

`ifdef MISALIGN_TRAP_EN
        if (w_misalign) begin
            state_d   = S_HALT;
            drop_d    = 1'b0;
            r_trap_d  = 1'b1;
            trap_pc_d = w_target;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_trap_q  <= 1'b0;
            trap_pc_q <= '0;
        end else begin
            r_trap_q  <= r_trap_d;
            trap_pc_q <= trap_pc_d;
        end
    end
`endif

    // Address is zeroed when no request is offered so idle outputs read 0.
    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = w_req_valid ? pc_q : '0;
    assign bus.if_valid       = w_if_valid;
    assign bus.if_pc          = if_pc_q;
    assign bus.if_instr       = if_instr_q;
    assign bus.redirect       = w_redirect;

endmodule
`default_nettype wire

// File: tb/tb_rv_fetch_branch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_rv_fetch_branch_unit
//  Description : Directed self-checking bench for rv_fetch_branch_unit with
//                PC_WIDTH=8, XLEN=32, RESET_PC=8'h10 and a 1-cycle imem
//                model returning 32'h1300_00<addr> for each fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_fetch_branch_unit;

    localparam int         PW  = 8;
    localparam int         XL  = 32;
    localparam logic [7:0] RPC = 8'h10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #50 clk = ~clk;

    rv_fetch_branch_unit_if #(.PC_WIDTH(PW), .XLEN(XL)) bus ();

    rv_fetch_branch_unit #(
        .PC_WIDTH (PW),
        .XLEN     (XL),
        .RESET_PC (RPC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int   n_assert = 0;
    int   n_fail   = 0;
    logic mem_en   = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: capture the request handshake before the edge, then drive
    // the 1-cycle imem response just after it.
    task automatic tick();
        logic       acc;
        logic [7:0] a;
        acc = bus.imem_req_valid & bus.imem_req_ready;
        a   = bus.imem_req_addr;
        @(posedge clk);
        #1;
        bus.imem_rsp_valid = acc & mem_en;
        bus.imem_rsp_data  = 32'h1300_0000 | {24'h0, a};
    endtask

    task automatic ex_set(input logic [1:0] kind, input logic [2:0] f3,
                          input logic [7:0] pc, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] imm);
        bus.ex_valid  = 1'b1;
        bus.ex_kind   = kind;
        bus.ex_funct3 = f3;
        bus.ex_pc     = pc;
        bus.ex_rs1    = rs1;
        bus.ex_rs2    = rs2;
        bus.ex_imm    = imm;
        #1;
    endtask

    task automatic ex_clr();
        bus.ex_valid = 1'b0;
        bus.ex_kind  = 2'b11;
        #1;
    endtask

    initial begin : main
        logic [7:0] e;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.if_ready       = 1'b1;
        bus.ex_valid       = 1'b0;
        bus.ex_kind        = 2'b11;
        bus.ex_funct3      = 3'b000;
        bus.ex_pc          = '0;
        bus.ex_rs1         = '0;
        bus.ex_rs2         = '0;
        bus.ex_imm         = '0;

        // Reset state
        tick(); tick();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_req_addr",  32'(bus.imem_req_addr),  32'd0);
        chk("rst_if_valid",  32'(bus.if_valid),       32'd0);
        chk("rst_trap",      32'(bus.trap),           32'd0);
        chk("rst_if_pc",     32'(bus.if_pc),          32'd0);
        chk("rst_if_instr",  bus.if_instr,            32'd0);
        chk("rst_redirect",  32'(bus.redirect),       32'd0);

        // Sequential fetch, 3 cycles per instruction
        reset = 1'b0;
        tick();
        chk("req0_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("req0_addr",  32'(bus.imem_req_addr),  32'h10);
        tick();
        chk("wait0_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("wait0_if_valid",  32'(bus.if_valid),       32'd0);
        tick();
        chk("hold0_if_valid", 32'(bus.if_valid), 32'd1);
        chk("hold0_if_pc",    32'(bus.if_pc),    32'h10);
        chk("hold0_if_instr", bus.if_instr,      32'h1300_0010);
        tick();
        chk("req1_addr", 32'(bus.imem_req_addr), 32'h14);
        tick(); tick();
        chk("hold1_if_pc", 32'(bus.if_pc), 32'h14);
        tick();
        chk("req2_addr", 32'(bus.imem_req_addr), 32'h18);
        tick(); tick();
        chk("hold2_if_pc",    32'(bus.if_pc), 32'h18);
        chk("hold2_if_instr", bus.if_instr,   32'h1300_0018);

        // Signed-lt branch taken from HOLD: 0x20 + (-8) = 0x18
        ex_set(2'b00, 3'b100, 8'h20, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8);
        chk("blt_redirect",      32'(bus.redirect), 32'd1);
        chk("blt_if_valid_kill", 32'(bus.if_valid), 32'd0);
        tick();
        chk("blt_req_addr", 32'(bus.imem_req_addr), 32'h18);
        // Same operands unsigned: 0xFFFFFFFF < 1 is false
        bus.imem_req_ready = 1'b0;
        ex_set(2'b00, 3'b110, 8'h20, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8);
        chk("bltu_no_redirect", 32'(bus.redirect), 32'd0);

        // Condition sweep over all funct3 (bit f3 of e = expected taken)
        e = 8'h92;
        for (int f = 0; f < 8; f++) begin
            ex_set(2'b00, 3'(f), 8'h20, 32'hFFFF_FFFF, 32'd1, 32'd0);
            chk($sformatf("cond_m1_1_f%0d", f), 32'(bus.redirect), 32'(e[f]));
        end
        e = 8'hA1;
        for (int f = 0; f < 8; f++) begin
            ex_set(2'b00, 3'(f), 8'h20, 32'd5, 32'd5, 32'd0);
            chk($sformatf("cond_eq_f%0d", f), 32'(bus.redirect), 32'(e[f]));
        end
        e = 8'h62;
        for (int f = 0; f < 8; f++) begin
            ex_set(2'b00, 3'(f), 8'h20, 32'd1, 32'hFFFF_FFFF, 32'd0);
            chk($sformatf("cond_1_m1_f%0d", f), 32'(bus.redirect), 32'(e[f]));
        end
        ex_set(2'b01, 3'b010, 8'h20, 32'd0, 32'd0, 32'd0);
        chk("jal_redirect", 32'(bus.redirect), 32'd1);
        ex_set(2'b11, 3'b000, 8'h20, 32'd5, 32'd5, 32'd0);
        chk("none_no_redirect", 32'(bus.redirect), 32'd0);
        ex_set(2'b01, 3'b000, 8'h20, 32'd0, 32'd0, 32'd0);
        bus.ex_valid = 1'b0;
        #1;
        chk("jal_invalid_no_redirect", 32'(bus.redirect), 32'd0);
        ex_clr();
        tick();
        chk("req_stall_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("req_stall_addr",  32'(bus.imem_req_addr),  32'h18);

        // Redirect in REQ without ready: address changes to target
        ex_set(2'b01, 3'b000, 8'h40, 32'd0, 32'd0, 32'h10);
        tick();
        ex_clr();
        chk("req_redir_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("req_redir_addr",  32'(bus.imem_req_addr),  32'h50);

        // Redirect in WAIT, stale response arrives the following cycle
        mem_en = 1'b0;
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        chk("wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
        ex_set(2'b01, 3'b000, 8'h60, 32'd0, 32'd0, 32'h20);
        tick();
        ex_clr();
        chk("wait_redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("wait_redir_if_valid",  32'(bus.if_valid),       32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        chk("stale_if_valid",  32'(bus.if_valid),       32'd0);
        chk("stale_if_instr",  bus.if_instr,            32'h1300_0018);
        chk("stale_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("stale_req_addr",  32'(bus.imem_req_addr),  32'h80);
        mem_en = 1'b1;
        bus.imem_req_ready = 1'b1;
        tick(); tick();
        chk("tgt_hold_if_valid", 32'(bus.if_valid), 32'd1);
        chk("tgt_hold_if_pc",    32'(bus.if_pc),    32'h80);
        chk("tgt_hold_if_instr", bus.if_instr,      32'h1300_0080);

        // HOLD with decode stalled for 5 cycles, then redirect
        bus.if_ready = 1'b0;
        repeat (5) tick();
        chk("stall_if_valid",  32'(bus.if_valid),       32'd1);
        chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        ex_set(2'b00, 3'b000, 8'h80, 32'd7, 32'd7, 32'h0C);
        chk("hold_redir",          32'(bus.redirect), 32'd1);
        chk("hold_redir_if_valid", 32'(bus.if_valid), 32'd0);
        tick();
        ex_clr();
        bus.if_ready = 1'b1;
        chk("hold_redir_req_addr", 32'(bus.imem_req_addr), 32'h8C);

        // Redirect in REQ with ready: accepted request is dropped
        ex_set(2'b01, 3'b000, 8'h00, 32'd0, 32'd0, 32'h24);
        tick();
        ex_clr();
        chk("reqrdy_wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
        tick();
        chk("reqrdy_drop_if_valid", 32'(bus.if_valid),       32'd0);
        chk("reqrdy_req_addr",      32'(bus.imem_req_addr),  32'h24);
        tick(); tick();
        chk("reqrdy_hold_if_pc",    32'(bus.if_pc), 32'h24);
        chk("reqrdy_hold_if_instr", bus.if_instr,   32'h1300_0024);

`ifdef MISALIGN_TRAP_EN
        // JALR 0xF3+0x10 -> 0x03 & ~1 = 0x02: misaligned, trap and halt
        ex_set(2'b10, 3'b000, 8'h00, 32'h0000_00F3, 32'd0, 32'h10);
        chk("jalr_redirect", 32'(bus.redirect), 32'd1);
        tick();
        ex_clr();
        chk("jalr_trap",      32'(bus.trap),           32'd1);
        chk("jalr_trap_pc",   32'(bus.trap_pc),        32'h02);
        chk("jalr_halt_req",  32'(bus.imem_req_valid), 32'd0);
        tick();
        chk("jalr_trap_pulse", 32'(bus.trap),           32'd0);
        chk("halt_if_valid",   32'(bus.if_valid),       32'd0);
        tick(); tick();
        chk("halt_req_valid",  32'(bus.imem_req_valid), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("post_halt_req_addr", 32'(bus.imem_req_addr), 32'h10);
        ex_set(2'b01, 3'b000, 8'h00, 32'd0, 32'd0, 32'd6);
        tick();
        ex_clr();
        chk("jal6_trap",    32'(bus.trap),    32'd1);
        chk("jal6_trap_pc", 32'(bus.trap_pc), 32'h06);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("jal6_halt_req_%0d", k), 32'(bus.imem_req_valid), 32'd0);
        end
        chk("jal6_trap_clear", 32'(bus.trap), 32'd0);
`else
        // JALR 0xF3+0x10 wraps to 0x03, bit0 cleared, low bits forced -> 0x00
        ex_set(2'b10, 3'b000, 8'h00, 32'h0000_00F3, 32'd0, 32'h10);
        chk("jalr_redirect", 32'(bus.redirect), 32'd1);
        tick();
        ex_clr();
        chk("jalr_req_addr", 32'(bus.imem_req_addr), 32'h00);
        chk("jalr_trap",     32'(bus.trap),          32'd0);
        chk("jalr_trap_pc",  32'(bus.trap_pc),       32'h00);
        // JAL 0+6 -> 0x04 once the low bits are forced
        ex_set(2'b01, 3'b000, 8'h00, 32'd0, 32'd0, 32'd6);
        tick();
        ex_clr();
        tick();
        chk("jal6_req_addr", 32'(bus.imem_req_addr), 32'h04);
        chk("jal6_trap",     32'(bus.trap),          32'd0);

        // Reset in WAIT with a response in flight
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("midrst_if_valid",  32'(bus.if_valid),       32'd0);
        chk("midrst_if_pc",     32'(bus.if_pc),          32'd0);
        reset = 1'b0;
        tick();
        chk("midrst_req_addr", 32'(bus.imem_req_addr), 32'h10);
        tick(); tick();
        chk("midrst_hold_if_pc",    32'(bus.if_pc), 32'h10);
        chk("midrst_hold_if_instr", bus.if_instr,   32'h1300_0010);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
